stream_seq_ctrl: RTL and testbench

Sequencer that runs the streaming kernel (`func_hdl_top`) over arrays held in on-chip or DRAM-backed buffers. It generates linear read addresses for the NIN input arrays, forwards read data to the kernel's AXI-stream slave under backpressure, and generates write addresses for kernel results. It repeats the sweep for a configured number of work instances and pulses `done` when the last result has been written. It sits between the memory shell and `func_hdl_top`, replacing the testbench-style free-running index counters.

---
 rtl/stream_seq_pkg.sv | 23 ++
 rtl/stream_seq_ctrl_if.sv | 54 +++++
 rtl/stream_skid_fifo.sv | 57 +++++
 rtl/stream_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_stream_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : stream_seq_pkg
// Purpose  : Shared state encoding and width helpers for the stream sequencer.
// Revision : 1.0
// ============================================================================
package stream_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int c_nwi_w = 16;

   function automatic int beat_w(input int dataw, input int gvect, input int n);
      return dataw * gvect * n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : stream_seq_ctrl_if
// Purpose   : Control, memory, kernel-stream and write-sink signals of the
//             stream sequencer.
// Revision  : 1.0
// ============================================================================
interface stream_seq_ctrl_if
   import stream_seq_pkg::*;
#(
   parameter int DATAW = 32,
   parameter int GVECT = 1,
   parameter int NIN   = 2,
   parameter int NOUT  = 1,
   parameter int ADDRW = 20
);
   localparam int c_in_w  = beat_w(DATAW, GVECT, NIN);
   localparam int c_out_w = beat_w(DATAW, GVECT, NOUT);

   logic                 start;
   logic [ADDRW:0]       cfg_size;
   logic [c_nwi_w-1:0]   cfg_nwi;
   logic                 busy;
   logic                 done;
   logic                 rd_en;
   logic [ADDRW-1:0]     rd_addr;
   logic [c_in_w-1:0]    rd_data;
   logic [NIN-1:0]       k_s_tvalid;
   logic [c_in_w-1:0]    k_s_tdata;
   logic [NIN-1:0]       k_s_tready;
   logic                 k_m_tvalid;
   logic [c_out_w-1:0]   k_m_tdata;
   logic                 k_m_tready;
   logic                 wr_en;
   logic [ADDRW-1:0]     wr_addr;
   logic [c_out_w-1:0]   wr_data;
   logic                 wr_ready;

   modport master (
      input  start, cfg_size, cfg_nwi, rd_data, k_s_tready,
             k_m_tvalid, k_m_tdata, wr_ready,
      output busy, done, rd_en, rd_addr, k_s_tvalid, k_s_tdata,
             k_m_tready, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, cfg_size, cfg_nwi, rd_data, k_s_tready,
             k_m_tvalid, k_m_tdata, wr_ready,
      input  busy, done, rd_en, rd_addr, k_s_tvalid, k_s_tdata,
             k_m_tready, wr_en, wr_addr, wr_data
   );

endinterface
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid_fifo
// Purpose  : Two-entry FIFO with occupancy count; head is valid when cnt != 0.
// Revision : 1.0
// ============================================================================
module stream_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       cnt
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_cnt;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A push into a full FIFO is only legal when the head leaves in the same cycle
   assign w_pop_ok  = pop && (r_cnt != 2'd0);
   assign w_push_ok = push && ((r_cnt != 2'd2) || w_pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign head = r_mem[r_rd_ptr];
   assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/stream_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stream_seq_ctrl
// Purpose  : Sweeps linear read/write addresses over NIN input arrays for a
//            number of work instances, feeding a streaming kernel.
// Revision : 1.0
// ============================================================================
module stream_seq_ctrl
   import stream_seq_pkg::*;
#(
   parameter int DATAW = 32,
   parameter int GVECT = 1,
   parameter int NIN   = 2,
   parameter int NOUT  = 1,
   parameter int ADDRW = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   stream_seq_ctrl_if.master  bus
);

   localparam int             c_in_w = beat_w(DATAW, GVECT, NIN);
   localparam logic [ADDRW:0] c_gv   = (ADDRW+1)'(GVECT);
   localparam logic [ADDRW-1:0] c_step = ADDRW'(GVECT);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDRW-1:0]     r_last_addr;
   logic [c_nwi_w-1:0]   r_nwi_last;
   logic                 r_inflight;
   logic [ADDRW:0]       w_size_beats;
   logic                 w_cfg_ok;
   logic                 w_launch;
   logic [1:0]           w_fifo_cnt;
   logic                 w_fifo_valid;
   logic [c_in_w-1:0]    w_fifo_head;
   logic                 w_pop;
   logic [2:0]           w_occupancy;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_rd_en;
   logic                 w_k_m_tready;
   logic                 w_wr_en;
   logic [1:0]           w_adv;
   logic [1:0]           w_last;
   logic [1:0][ADDRW-1:0] w_addr;

   assign w_size_beats = bus.cfg_size / c_gv;
   assign w_cfg_ok     = (w_size_beats != '0) && (bus.cfg_nwi != '0);
   assign w_launch     = (r_state == ST_IDLE) && bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_addr <= '0;
         r_nwi_last  <= '0;
      end else if (w_launch && w_cfg_ok) begin
         r_last_addr <= ADDRW'((w_size_beats - (ADDRW+1)'(1)) * c_gv);
         r_nwi_last  <= bus.cfg_nwi - c_nwi_w'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start) w_state_nxt = w_cfg_ok ? ST_RUN : ST_DONE;
         ST_RUN:   if (w_rd_en && w_last[0]) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_wr_en && w_last[1]) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Beats already in the FIFO plus the one still returning from memory
   assign w_occupancy = {1'b0, w_fifo_cnt} - {2'b00, w_pop} + {2'b00, r_inflight};

   always_comb begin
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_rd_en      = 1'b0;
      w_k_m_tready = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_busy       = 1'b1;
            w_rd_en      = (w_occupancy < 3'd2);
            w_k_m_tready = bus.wr_ready;
         end
         ST_DRAIN: begin
            w_busy       = 1'b1;
            w_k_m_tready = bus.wr_ready;
         end
         ST_DONE: w_done = 1'b1;
         default: ;
      endcase
   end

   assign w_pop   = w_fifo_valid && (&bus.k_s_tready);
   assign w_wr_en = bus.k_m_tvalid && w_k_m_tready;
   assign w_adv   = {w_wr_en, w_rd_en};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
      end
   end

   // Index 0 walks the read side, index 1 the write side
   for (genvar g = 0; g < 2; g++) begin : g_addr_gen
      logic [ADDRW-1:0]   r_addr;
      logic [c_nwi_w-1:0] r_wi;
      logic               w_wrap;

      assign w_wrap    = (r_addr == r_last_addr);
      assign w_last[g] = w_wrap && (r_wi == r_nwi_last);
      assign w_addr[g] = r_addr;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_addr <= '0;
            r_wi   <= '0;
         end else if (w_launch) begin
            r_addr <= '0;
            r_wi   <= '0;
         end else if (w_adv[g]) begin
            if (w_wrap) begin
               r_addr <= '0;
               r_wi   <= w_last[g] ? '0 : r_wi + c_nwi_w'(1);
            end else begin
               r_addr <= r_addr + c_step;
            end
         end
      end
   end

   stream_skid_fifo #(
      .WIDTH (c_in_w)
   ) u_in_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (r_inflight),
      .push_data (bus.rd_data),
      .pop       (w_pop),
      .head      (w_fifo_head),
      .cnt       (w_fifo_cnt)
   );

   assign w_fifo_valid   = (w_fifo_cnt != 2'd0);

   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.rd_en      = w_rd_en;
   assign bus.rd_addr    = w_addr[0];
   assign bus.k_s_tvalid = {NIN{w_fifo_valid}};
   assign bus.k_s_tdata  = w_fifo_head;
   assign bus.k_m_tready = w_k_m_tready;
   assign bus.wr_en      = w_wr_en;
   assign bus.wr_addr    = w_addr[1];
   assign bus.wr_data    = w_busy ? bus.k_m_tdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_stream_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_seq_ctrl
// Purpose  : Randomized scoreboard bench for stream_seq_ctrl with a memory and
//            kernel model (kernel output = stream0 - stream1 per element).
// Revision : 1.0
// ============================================================================
module tb_stream_seq_ctrl;

   localparam int DATAW = 8;
   localparam int GVECT = 2;
   localparam int NIN   = 2;
   localparam int NOUT  = 1;
   localparam int ADDRW = 8;
   localparam int SW    = DATAW * GVECT;
   localparam int IN_W  = SW * NIN;
   localparam int OUT_W = SW * NOUT;

   typedef struct packed {
      logic [ADDRW-1:0] a;
      logic [OUT_W-1:0] d;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stream_seq_ctrl_if #(
      .DATAW(DATAW), .GVECT(GVECT), .NIN(NIN), .NOUT(NOUT), .ADDRW(ADDRW)
   ) bus ();

   stream_seq_ctrl #(
      .DATAW(DATAW), .GVECT(GVECT), .NIN(NIN), .NOUT(NOUT), .ADDRW(ADDRW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DATAW-1:0] mem0 [0:300];
   logic [DATAW-1:0] mem1 [0:300];
   logic [OUT_W-1:0] kq [$];
   logic [ADDRW-1:0] exp_rd [$];
   wr_t              exp_wr [$];

   int  checks = 0;
   int  failures = 0;
   int  k_rdy_pct = 100;
   int  w_rdy_pct = 100;
   bit  k_stall = 1'b0;
   bit  run_active = 1'b0;
   bit  done_due = 1'b0;
   int  done_cnt = 0;
   int  n_rd = 0, n_rd_prev = 0, n_pop = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [IN_W-1:0] pack_rd(input int a);
      logic [IN_W-1:0] v = '0;
      for (int e = 0; e < GVECT; e++) begin
         v[SW + e*DATAW +: DATAW] = mem0[a+e];
         v[e*DATAW +: DATAW]      = mem1[a+e];
      end
      return v;
   endfunction

   function automatic logic [OUT_W-1:0] kern(input logic [IN_W-1:0] d);
      logic [OUT_W-1:0] o = '0;
      for (int e = 0; e < GVECT; e++)
         o[e*DATAW +: DATAW] = d[SW + e*DATAW +: DATAW] - d[e*DATAW +: DATAW];
      return o;
   endfunction

   function automatic logic [OUT_W-1:0] exp_out(input int a);
      logic [OUT_W-1:0] o = '0;
      for (int e = 0; e < GVECT; e++)
         o[e*DATAW +: DATAW] = mem0[a+e] - mem1[a+e];
      return o;
   endfunction

   // Memory and kernel responders
   logic             e_rd, e_pin, e_pout;
   logic [ADDRW-1:0] e_addr;
   logic [IN_W-1:0]  e_din;
   always begin
      @(posedge clk);
      e_rd   = bus.rd_en;
      e_addr = bus.rd_addr;
      e_pin  = bus.k_s_tvalid[0] && (&bus.k_s_tready);
      e_din  = bus.k_s_tdata;
      e_pout = bus.k_m_tvalid && bus.k_m_tready;
      #1;
      if (!rst_n) begin
         kq.delete();
         bus.rd_data    = '0;
         bus.k_s_tready = '0;
         bus.k_m_tvalid = 1'b0;
         bus.k_m_tdata  = '0;
         bus.wr_ready   = 1'b0;
      end else begin
         bus.rd_data = e_rd ? pack_rd(int'(e_addr)) : IN_W'($urandom);
         if (e_pout && kq.size() > 0) void'(kq.pop_front());
         if (e_pin) kq.push_back(kern(e_din));
         bus.k_m_tvalid = (kq.size() > 0);
         bus.k_m_tdata  = (kq.size() > 0) ? kq[0] : '0;
         bus.k_s_tready = (!k_stall && ($urandom_range(99) < k_rdy_pct) && kq.size() < 4)
                          ? '1 : NIN'($urandom_range(2));
         bus.wr_ready   = ($urandom_range(99) < w_rdy_pct);
      end
   end

   // Monitor / scoreboard
   int  occ;
   wr_t got;
   always @(negedge clk) begin
      if (!rst_n) begin
         n_rd = 0; n_rd_prev = 0; n_pop = 0;
      end else begin
         occ = n_rd_prev - n_pop;
         chk("fifo_bound", (occ <= 2), 1);
         chk("k_s_tvalid", bus.k_s_tvalid, (occ > 0) ? 2'b11 : 2'b00);
         chk("busy", bus.busy, run_active);
         chk("k_m_tready", bus.k_m_tready, run_active && bus.wr_ready);
         chk("wr_en", bus.wr_en, bus.k_m_tvalid && run_active && bus.wr_ready);
         chk("done", bus.done, done_due);
         done_due = 1'b0;
         if (bus.done) done_cnt++;
         if (bus.rd_en) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", bus.rd_addr, 64'hDEAD);
            else chk("rd_addr", bus.rd_addr, exp_rd.pop_front());
         end
         if (bus.wr_en) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", bus.wr_addr, 64'hDEAD);
            else begin
               got = exp_wr.pop_front();
               chk("wr_addr", bus.wr_addr, got.a);
               chk("wr_data", bus.wr_data, got.d);
               if (exp_wr.size() == 0) begin
                  run_active = 1'b0;
                  done_due   = 1'b1;
               end
            end
         end
         n_rd_prev = n_rd;
         n_rd      = n_rd + int'(bus.rd_en);
         n_pop     = n_pop + int'(bus.k_s_tvalid[0] && (&bus.k_s_tready));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int size, input int nwi, input int krdy, input int wrdy,
                      input bit burst, input bit restart, input bit stall);
      int beats = size / GVECT;
      int guard = 0;
      int base;
      for (int i = 0; i <= 300; i++) begin
         mem0[i] = DATAW'($urandom);
         mem1[i] = DATAW'($urandom);
      end
      k_rdy_pct = krdy;
      w_rdy_pct = wrdy;
      if (beats > 0 && nwi > 0)
         for (int w = 0; w < nwi; w++)
            for (int b = 0; b < beats; b++) begin
               exp_rd.push_back(ADDRW'(b * GVECT));
               exp_wr.push_back('{a: ADDRW'(b * GVECT), d: exp_out(b * GVECT)});
            end
      base         = done_cnt;
      bus.cfg_size = (ADDRW+1)'(size);
      bus.cfg_nwi  = 16'(nwi);
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.cfg_size = (ADDRW+1)'($urandom);
      bus.cfg_nwi  = 16'($urandom);
      if (beats > 0 && nwi > 0) run_active = 1'b1;
      else done_due = 1'b1;
      if (burst) begin
         for (int i = 0; i < beats; i++) begin
            chk("burst_rd_en", bus.rd_en, 1);
            tick();
         end
         chk("burst_end_rd_en", bus.rd_en, 0);
      end
      if (restart) begin
         repeat (2) tick();
         bus.cfg_size = 9'd2;
         bus.cfg_nwi  = 16'd0;
         bus.start    = 1'b1;
         tick();
         bus.start    = 1'b0;
      end
      if (stall) begin
         repeat (3) tick();
         k_stall = 1'b1;
         repeat (3) tick();
         chk("stall_rd_en", bus.rd_en, 0);
         chk("stall_fifo_full", bus.k_s_tvalid, 2'b11);
         repeat (2) tick();
         k_stall = 1'b0;
      end
      while (done_cnt == base && guard < 3000) begin
         tick();
         guard++;
      end
      chk("run_done_timeout", (done_cnt != base), 1);
      repeat (4) tick();
      chk("done_pulses", done_cnt - base, 1);
      chk("scoreboard_empty", exp_rd.size() + exp_wr.size(), 0);
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.cfg_size   = '0;
      bus.cfg_nwi    = '0;
      bus.rd_data    = '0;
      bus.k_s_tready = '0;
      bus.k_m_tvalid = 1'b0;
      bus.k_m_tdata  = '0;
      bus.wr_ready   = 1'b0;
      repeat (3) tick();
      chk("reset_ctl", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.k_s_tvalid,
                        bus.k_m_tready, bus.wr_en, bus.wr_addr}, 0);
      chk("reset_data", {bus.k_s_tdata, bus.wr_data}, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      run(16, 1, 100, 100, 1'b1, 1'b0, 1'b0);   // basic burst, addr 0..14 step 2
      run(8, 3, 100, 100, 1'b0, 1'b0, 1'b0);    // three work instances
      run(9, 2, 100, 100, 1'b0, 1'b0, 1'b0);    // odd size: low bit ignored
      run(16, 2, 100, 100, 1'b0, 1'b0, 1'b1);   // kernel stall mid-run
      run(8, 0, 100, 100, 1'b0, 1'b0, 1'b0);    // zero work instances
      run(1, 3, 100, 100, 1'b0, 1'b0, 1'b0);    // size below one beat

      // Reset in the middle of a run
      for (int b = 0; b < 8; b++) begin
         exp_rd.push_back(ADDRW'(b * GVECT));
         exp_wr.push_back('{a: ADDRW'(b * GVECT), d: exp_out(b * GVECT)});
      end
      bus.cfg_size = 9'd16;
      bus.cfg_nwi  = 16'd1;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      run_active   = 1'b1;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ctl", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.k_s_tvalid,
                         bus.k_m_tready, bus.wr_en, bus.wr_addr}, 0);
      chk("midrst_data", {bus.k_s_tdata, bus.wr_data}, 0);
      exp_rd.delete();
      exp_wr.delete();
      run_active = 1'b0;
      done_due   = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      run(4, 1, 100, 100, 1'b0, 1'b0, 1'b0);

      run(8, 1, 100, 50, 1'b0, 1'b1, 1'b0);     // ignored restart, write stalls

      for (int r = 0; r < 6; r++)
         run(int'($urandom_range(2, 16)), int'($urandom_range(1, 3)),
             int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
             1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
